// File: rtl/ifetch.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch
//  Description : Instruction-fetch stage. Presents the PC to instruction
//                memory over a valid/ready request channel, accepts the
//                returned word and holds it in the IF/ID register. Drives
//                pause back to the PC register and drops in-flight fetches
//                on a redirect.
//  Revision    : 1.0  initial release
// ============================================================================
module ifetch #(
  parameter int unsigned XLEN = 32,
  parameter logic [31:0] NOP  = 32'h00000013
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  input  logic            flush,
  input  logic            id_stall,
  output logic            pause,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  output logic            imem_rsp_ready,
  input  logic [31:0]     imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_inst,
  output logic            if_fault
);

  // REQ : may issue a request for the current PC
  // WAIT: one request outstanding, waiting for its response
  // DROP: outstanding response belongs to a flushed path, discard it
  // HALT: a fault entry was produced, wait for a redirect
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   req_pc_q, req_pc_d;
  logic              if_valid_q, if_valid_d;
  logic [XLEN-1:0]   if_pc_q, if_pc_d;
  logic [31:0]       if_inst_q, if_inst_d;
  logic              if_fault_q, if_fault_d;

  logic              misaligned;
  logic              slot_free;
  logic              req_fire;
  logic              rsp_fire;

  // Load request produced by the state machine for the IF/ID register
  logic              load_en;
  logic [XLEN-1:0]   load_pc;
  logic [31:0]       load_inst;
  logic              load_fault;

  assign misaligned = (pc[1:0] != 2'b00);
  assign slot_free  = !if_valid_q || !id_stall;

  // Handshake outputs; everything is held quiet while reset is asserted
  always_comb begin
    imem_req_valid = 1'b0;
    imem_rsp_ready = 1'b0;
    if (!reset) begin
      imem_req_valid = (state_q == S_REQ) && !flush && !misaligned;
      imem_rsp_ready = ((state_q == S_WAIT) && slot_free) || (state_q == S_DROP);
    end
  end

  assign req_fire      = imem_req_valid && imem_req_ready;
  assign rsp_fire      = imem_rsp_valid && imem_rsp_ready;
  assign imem_req_addr = pc;
  // The PC moves only on an accepted request or a redirect
  assign pause         = reset || !(req_fire || flush);

  // Next-state logic and the IF/ID load request
  always_comb begin
    state_d    = state_q;
    load_en    = 1'b0;
    load_pc    = req_pc_q;
    load_inst  = NOP;
    load_fault = 1'b0;
    case (state_q)
      S_REQ: begin
        if (!flush) begin
          if (req_fire) begin
            state_d = S_WAIT;
          end else if (misaligned && slot_free) begin
            load_en    = 1'b1;
            load_pc    = pc;
            load_fault = 1'b1;
            state_d    = S_HALT;
          end
        end
      end
      S_WAIT: begin
        if (flush) begin
          // A word arriving with the redirect is simply dropped
          state_d = rsp_fire ? S_REQ : S_DROP;
        end else if (rsp_fire) begin
          load_en = 1'b1;
          if (imem_rsp_err) begin
            load_fault = 1'b1;
            state_d    = S_HALT;
          end else begin
            load_inst = imem_rsp_data;
            state_d   = S_REQ;
          end
        end
      end
      S_DROP: begin
        if (rsp_fire) begin
          state_d = S_REQ;
        end
      end
      S_HALT: begin
        if (flush) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  // Address of the request in flight, captured when memory accepts it
  always_comb begin
    req_pc_d = req_pc_q;
    if (req_fire) begin
      req_pc_d = pc;
    end
  end

  // IF/ID update: flush beats load, load beats consume, stall holds
  always_comb begin
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    if_fault_d = if_fault_q;
    if (flush) begin
      if_valid_d = 1'b0;
      if_inst_d  = NOP;
      if_fault_d = 1'b0;
    end else if (load_en) begin
      if_valid_d = 1'b1;
      if_pc_d    = load_pc;
      if_inst_d  = load_inst;
      if_fault_d = load_fault;
    end else if (!id_stall) begin
      if_valid_d = 1'b0;
      if_inst_d  = NOP;
      if_fault_d = 1'b0;
    end
  end

  // State and pipeline registers; reset abandons any outstanding fetch
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_REQ;
      req_pc_q   <= '0;
      if_valid_q <= 1'b0;
      if_pc_q    <= '0;
      if_inst_q  <= NOP;
      if_fault_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_pc_q   <= req_pc_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
      if_fault_q <= if_fault_d;
    end
  end

  assign if_valid = if_valid_q;
  assign if_pc    = if_pc_q;
  assign if_inst  = if_inst_q;
  assign if_fault = if_fault_q;

endmodule
`default_nettype wire

// File: tb/tb_ifetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ifetch
//  Description : Directed self-checking bench for the ifetch stage. Each task
//                plays the PC register and instruction memory cycle by cycle
//                and compares against hand-computed values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ifetch;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc = '0;
  logic        flush = 1'b0;
  logic        id_stall = 1'b0;
  logic        pause;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic        imem_rsp_ready;
  logic [31:0] imem_rsp_data = '0;
  logic        imem_rsp_err = 1'b0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_fault;

  int total = 0;
  int bad   = 0;

  // {req_valid, rsp_ready, pause}
  logic [2:0]  ctl;
  // {if_valid, if_fault, if_pc, if_inst}
  logic [65:0] ifid;
  // {if_valid, if_fault, if_inst} for cycles where if_pc is don't-care
  logic [33:0] ifvi;

  assign ctl  = {imem_req_valid, imem_rsp_ready, pause};
  assign ifid = {if_valid, if_fault, if_pc, if_inst};
  assign ifvi = {if_valid, if_fault, if_inst};

  ifetch #(.XLEN(32), .NOP(NOP)) dut (
    .clock          (clock),
    .reset          (reset),
    .pc             (pc),
    .flush          (flush),
    .id_stall       (id_stall),
    .pause          (pause),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_ready (imem_rsp_ready),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_inst        (if_inst),
    .if_fault       (if_fault)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input logic [31:0] p, input logic f, input logic s,
                        input logic rdy, input logic rv, input logic [31:0] d,
                        input logic e);
    pc             = p;
    flush          = f;
    id_stall       = s;
    imem_req_ready = rdy;
    imem_rsp_valid = rv;
    imem_rsp_data  = d;
    imem_rsp_err   = e;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_in(32'h0, 0, 0, 1, 0, 32'h0, 0);
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_in(32'h0, 0, 0, 1, 1, 32'h12345678, 0);
    tick();
    tick();
    total++; if (ctl !== 3'b001) begin bad++; $display("FAIL rst_ctl got=%b exp=%b", ctl, 3'b001); end
    total++; if (ifid !== {1'b0, 1'b0, 32'h0, NOP}) begin bad++; $display("FAIL rst_ifid got=%h exp=%h", ifid, {1'b0, 1'b0, 32'h0, NOP}); end
    reset = 1'b0;
    #1;
  endtask

  task automatic test_zero_wait();
    do_reset();
    set_in(32'h0, 0, 0, 1, 0, 32'h0, 0);
    total++; if (ctl !== 3'b100) begin bad++; $display("FAIL zw_req0 got=%b exp=%b", ctl, 3'b100); end
    total++; if (imem_req_addr !== 32'h0) begin bad++; $display("FAIL zw_addr0 got=%h exp=%h", imem_req_addr, 32'h0); end
    tick();
    set_in(32'h4, 0, 0, 1, 1, 32'h00100093, 0);
    total++; if (ctl !== 3'b011) begin bad++; $display("FAIL zw_wait0 got=%b exp=%b", ctl, 3'b011); end
    total++; if (ifvi !== {1'b0, 1'b0, NOP}) begin bad++; $display("FAIL zw_empty0 got=%h exp=%h", ifvi, {1'b0, 1'b0, NOP}); end
    tick();
    set_in(32'h4, 0, 0, 1, 0, 32'h0, 0);
    total++; if (ctl !== 3'b100) begin bad++; $display("FAIL zw_req4 got=%b exp=%b", ctl, 3'b100); end
    total++; if (ifid !== {1'b1, 1'b0, 32'h0, 32'h00100093}) begin bad++; $display("FAIL zw_out0 got=%h exp=%h", ifid, {1'b1, 1'b0, 32'h0, 32'h00100093}); end
    tick();
    set_in(32'h8, 0, 0, 1, 1, 32'h00200113, 0);
    total++; if (ctl !== 3'b011) begin bad++; $display("FAIL zw_wait4 got=%b exp=%b", ctl, 3'b011); end
    total++; if (ifvi !== {1'b0, 1'b0, NOP}) begin bad++; $display("FAIL zw_empty4 got=%h exp=%h", ifvi, {1'b0, 1'b0, NOP}); end
    tick();
    set_in(32'h8, 0, 0, 1, 0, 32'h0, 0);
    total++; if (imem_req_addr !== 32'h8) begin bad++; $display("FAIL zw_addr8 got=%h exp=%h", imem_req_addr, 32'h8); end
    total++; if (ifid !== {1'b1, 1'b0, 32'h4, 32'h00200113}) begin bad++; $display("FAIL zw_out4 got=%h exp=%h", ifid, {1'b1, 1'b0, 32'h4, 32'h00200113}); end
    tick();
    set_in(32'hC, 0, 0, 1, 1, 32'h00300193, 0);
    total++; if (ctl !== 3'b011) begin bad++; $display("FAIL zw_wait8 got=%b exp=%b", ctl, 3'b011); end
    tick();
    set_in(32'hC, 0, 0, 0, 0, 32'h0, 0);
    total++; if (ifid !== {1'b1, 1'b0, 32'h8, 32'h00300193}) begin bad++; $display("FAIL zw_out8 got=%h exp=%h", ifid, {1'b1, 1'b0, 32'h8, 32'h00300193}); end
    total++; if (ctl !== 3'b101) begin bad++; $display("FAIL zw_notready got=%b exp=%b", ctl, 3'b101); end
  endtask

  task automatic test_flush_wait();
    do_reset();
    set_in(32'h8, 0, 0, 1, 0, 32'h0, 0);
    total++; if (ctl !== 3'b100) begin bad++; $display("FAIL fw_req8 got=%b exp=%b", ctl, 3'b100); end
    tick();
    set_in(32'hC, 1, 0, 1, 0, 32'h0, 0);
    total++; if (ctl !== 3'b010) begin bad++; $display("FAIL fw_flush got=%b exp=%b", ctl, 3'b010); end
    tick();
    set_in(32'h40, 0, 0, 1, 1, 32'h00300193, 0);
    total++; if (ctl !== 3'b011) begin bad++; $display("FAIL fw_drop got=%b exp=%b", ctl, 3'b011); end
    total++; if (ifvi !== {1'b0, 1'b0, NOP}) begin bad++; $display("FAIL fw_empty got=%h exp=%h", ifvi, {1'b0, 1'b0, NOP}); end
    tick();
    set_in(32'h40, 0, 0, 1, 0, 32'h0, 0);
    total++; if (ctl !== 3'b100) begin bad++; $display("FAIL fw_req40 got=%b exp=%b", ctl, 3'b100); end
    total++; if (imem_req_addr !== 32'h40) begin bad++; $display("FAIL fw_addr40 got=%h exp=%h", imem_req_addr, 32'h40); end
    total++; if (ifvi !== {1'b0, 1'b0, NOP}) begin bad++; $display("FAIL fw_discard got=%h exp=%h", ifvi, {1'b0, 1'b0, NOP}); end
    tick();
    set_in(32'h44, 0, 0, 1, 1, 32'h00500293, 0);
    tick();
    set_in(32'h44, 0, 0, 0, 0, 32'h0, 0);
    total++; if (ifid !== {1'b1, 1'b0, 32'h40, 32'h00500293}) begin bad++; $display("FAIL fw_out40 got=%h exp=%h", ifid, {1'b1, 1'b0, 32'h40, 32'h00500293}); end
  endtask

  task automatic test_flush_rsp();
    do_reset();
    set_in(32'h10, 0, 0, 1, 0, 32'h0, 0);
    tick();
    set_in(32'h14, 1, 0, 1, 1, 32'h00600313, 0);
    total++; if (ctl !== 3'b010) begin bad++; $display("FAIL fr_flush got=%b exp=%b", ctl, 3'b010); end
    tick();
    set_in(32'h80, 0, 0, 1, 0, 32'h0, 0);
    total++; if (ifvi !== {1'b0, 1'b0, NOP}) begin bad++; $display("FAIL fr_discard got=%h exp=%h", ifvi, {1'b0, 1'b0, NOP}); end
    total++; if (ctl !== 3'b100 || imem_req_addr !== 32'h80) begin bad++; $display("FAIL fr_req80 got=%b/%h exp=%b/%h", ctl, imem_req_addr, 3'b100, 32'h80); end
    tick();
    set_in(32'h84, 0, 0, 1, 1, 32'h00700393, 0);
    tick();
    set_in(32'h84, 0, 0, 0, 0, 32'h0, 0);
    total++; if (ifid !== {1'b1, 1'b0, 32'h80, 32'h00700393}) begin bad++; $display("FAIL fr_out80 got=%h exp=%h", ifid, {1'b1, 1'b0, 32'h80, 32'h00700393}); end
  endtask

  task automatic test_stall();
    do_reset();
    set_in(32'h0, 0, 0, 1, 0, 32'h0, 0);
    tick();
    set_in(32'h4, 0, 0, 1, 1, 32'h00100093, 0);
    tick();
    set_in(32'h4, 0, 1, 1, 0, 32'h0, 0);
    total++; if (ctl !== 3'b100) begin bad++; $display("FAIL st_req4 got=%b exp=%b", ctl, 3'b100); end
    tick();
    for (int i = 0; i < 3; i++) begin
      set_in(32'h8, 0, 1, 1, 1, 32'h00200113, 0);
      total++; if (ctl !== 3'b001) begin bad++; $display("FAIL st_block%0d got=%b exp=%b", i, ctl, 3'b001); end
      total++; if (ifid !== {1'b1, 1'b0, 32'h0, 32'h00100093}) begin bad++; $display("FAIL st_hold%0d got=%h exp=%h", i, ifid, {1'b1, 1'b0, 32'h0, 32'h00100093}); end
      tick();
    end
    set_in(32'h8, 0, 0, 1, 1, 32'h00200113, 0);
    total++; if (ctl !== 3'b011) begin bad++; $display("FAIL st_release got=%b exp=%b", ctl, 3'b011); end
    tick();
    set_in(32'h8, 0, 0, 0, 0, 32'h0, 0);
    total++; if (ifid !== {1'b1, 1'b0, 32'h4, 32'h00200113}) begin bad++; $display("FAIL st_out4 got=%h exp=%h", ifid, {1'b1, 1'b0, 32'h4, 32'h00200113}); end
  endtask

  task automatic test_misaligned();
    do_reset();
    set_in(32'h6, 0, 0, 1, 0, 32'h0, 0);
    total++; if (ctl !== 3'b001) begin bad++; $display("FAIL ma_noreq got=%b exp=%b", ctl, 3'b001); end
    tick();
    set_in(32'h6, 0, 1, 1, 0, 32'h0, 0);
    total++; if (ifid !== {1'b1, 1'b1, 32'h6, NOP}) begin bad++; $display("FAIL ma_fault got=%h exp=%h", ifid, {1'b1, 1'b1, 32'h6, NOP}); end
    total++; if (ctl !== 3'b001) begin bad++; $display("FAIL ma_halt got=%b exp=%b", ctl, 3'b001); end
    tick();
    set_in(32'h6, 0, 0, 1, 0, 32'h0, 0);
    total++; if (ifid !== {1'b1, 1'b1, 32'h6, NOP}) begin bad++; $display("FAIL ma_held got=%h exp=%h", ifid, {1'b1, 1'b1, 32'h6, NOP}); end
    tick();
    set_in(32'h6, 0, 0, 1, 0, 32'h0, 0);
    total++; if (ifvi !== {1'b0, 1'b0, NOP}) begin bad++; $display("FAIL ma_consumed got=%h exp=%h", ifvi, {1'b0, 1'b0, NOP}); end
    total++; if (ctl !== 3'b001) begin bad++; $display("FAIL ma_paused got=%b exp=%b", ctl, 3'b001); end
    tick();
    set_in(32'h6, 1, 0, 1, 0, 32'h0, 0);
    total++; if (ctl !== 3'b000) begin bad++; $display("FAIL ma_flush got=%b exp=%b", ctl, 3'b000); end
    tick();
    set_in(32'h100, 0, 0, 1, 0, 32'h0, 0);
    total++; if (ctl !== 3'b100 || imem_req_addr !== 32'h100) begin bad++; $display("FAIL ma_resume got=%b/%h exp=%b/%h", ctl, imem_req_addr, 3'b100, 32'h100); end
    tick();
    set_in(32'h104, 0, 0, 1, 1, 32'h00800413, 0);
    tick();
    set_in(32'h104, 0, 0, 0, 0, 32'h0, 0);
    total++; if (ifid !== {1'b1, 1'b0, 32'h100, 32'h00800413}) begin bad++; $display("FAIL ma_out100 got=%h exp=%h", ifid, {1'b1, 1'b0, 32'h100, 32'h00800413}); end
  endtask

  task automatic test_err_reset();
    do_reset();
    set_in(32'h20, 0, 0, 1, 0, 32'h0, 0);
    tick();
    set_in(32'h24, 0, 0, 1, 1, 32'hFFFFFFFF, 1);
    total++; if (ctl !== 3'b011) begin bad++; $display("FAIL er_wait got=%b exp=%b", ctl, 3'b011); end
    tick();
    set_in(32'h24, 0, 1, 1, 0, 32'h0, 0);
    total++; if (ifid !== {1'b1, 1'b1, 32'h20, NOP}) begin bad++; $display("FAIL er_fault got=%h exp=%h", ifid, {1'b1, 1'b1, 32'h20, NOP}); end
    total++; if (ctl !== 3'b001) begin bad++; $display("FAIL er_halt got=%b exp=%b", ctl, 3'b001); end
    tick();
    set_in(32'h24, 1, 0, 1, 0, 32'h0, 0);
    tick();
    set_in(32'h24, 0, 0, 1, 0, 32'h0, 0);
    total++; if (ctl !== 3'b100) begin bad++; $display("FAIL er_resume got=%b exp=%b", ctl, 3'b100); end
    tick();
    set_in(32'h28, 0, 0, 1, 1, 32'h00900493, 0);
    tick();
    set_in(32'h28, 0, 1, 1, 0, 32'h0, 0);
    total++; if (ifid !== {1'b1, 1'b0, 32'h24, 32'h00900493}) begin bad++; $display("FAIL er_out24 got=%h exp=%h", ifid, {1'b1, 1'b0, 32'h24, 32'h00900493}); end
    tick();
    reset = 1'b1;
    set_in(32'h2C, 0, 1, 1, 0, 32'h0, 0);
    total++; if (ctl !== 3'b001) begin bad++; $display("FAIL er_inreset got=%b exp=%b", ctl, 3'b001); end
    tick();
    reset = 1'b0;
    set_in(32'h0, 0, 0, 0, 0, 32'h0, 0);
    total++; if (ifid !== {1'b0, 1'b0, 32'h0, NOP}) begin bad++; $display("FAIL er_rstifid got=%h exp=%h", ifid, {1'b0, 1'b0, 32'h0, NOP}); end
    total++; if (ctl !== 3'b101) begin bad++; $display("FAIL er_rststate got=%b exp=%b", ctl, 3'b101); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_flush_wait();
    test_flush_rsp();
    test_stall();
    test_misaligned();
    test_err_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ifetch.md
# ifetch

Instruction-fetch stage between the program counter register and the decode stage. Each cycle it may present the current `pc` to instruction memory over a valid/ready request channel, accept the returned word on a response channel, and hold it in the IF/ID output register. It drives `pause` back to the PC register so the PC advances only when a fetch request is accepted or a redirect arrives. It discards in-flight fetches on `flush`.

## Interface
- `XLEN`, 32, address/PC width
- `NOP`, 32'h00000013, instruction word presented whenever `if_valid`=0 or on a fault
- `clock` in 1: single clock, all state on rising edge
- `reset` in 1: synchronous, active-high
- `pc` in XLEN: current PC register value
- `flush` in 1: redirect from EX (branch taken or jump); PC loads the target this cycle
- `id_stall` in 1: decode cannot consume the IF/ID register this cycle
- `pause` out 1: combinational, holds the PC register
- `imem_req_valid` out 1: fetch request valid
- `imem_req_ready` in 1: memory accepts the request
- `imem_req_addr` out XLEN: always equal to `pc`
- `imem_rsp_valid` in 1: response word valid
- `imem_rsp_ready` out 1: the stage accepts the response
- `imem_rsp_data` in 32: instruction word
- `imem_rsp_err` in 1: access fault, qualified by `imem_rsp_valid`
- `if_valid` out 1: IF/ID register holds a live instruction
- `if_pc` out XLEN: PC of `if_inst`
- `if_inst` out 32: instruction word to decode
- `if_fault` out 1: `if_inst` is a fetch fault (misaligned or access error)

## Operation
- Signal definitions:
  - req_fire = `imem_req_valid` & `imem_req_ready`.
  - rsp_fire = `imem_rsp_valid` & `imem_rsp_ready`.
  - slot_free = !`if_valid` | !`id_stall`.
- States and transitions:
  - REQ
    - `imem_req_valid` = !`flush` & (`pc[1:0]`==0).
    - req_fire → WAIT.
    - With `pc[1:0]`!=0 and slot_free and !`flush`: load the fault entry into IF/ID, then → HALT.
  - WAIT
    - `imem_rsp_ready` = slot_free.
    - rsp_fire & !`flush`: load IF/ID, then → REQ. If `imem_rsp_err`=1, load the fault entry instead and → HALT.
    - `flush` without rsp_fire → DROP.
    - `flush` with rsp_fire: discard the word and → REQ.
  - DROP
    - `imem_rsp_ready`=1.
    - rsp_fire → REQ, word discarded.
    - A further `flush` keeps the state in DROP.
  - HALT
    - No requests.
    - `flush` → REQ.
- `imem_rsp_ready`=0 in REQ and HALT.
- `pause` = !(req_fire | `flush`).
  - The PC advances exactly once per accepted request.
  - The PC always loads the redirect target on `flush`.
- IF/ID register update:
  - Load: `if_valid`=1, `if_pc`=address of the request being answered (latched at req_fire, or `pc` for a misaligned fault), `if_inst`=data. On a fault, `if_inst`=`NOP` and `if_fault`=1.
  - `flush`: `if_valid`=0, `if_inst`=`NOP`, `if_fault`=0. This overrides any load.
  - Consumed with no load (!`id_stall`): `if_valid`=0, `if_inst`=`NOP`, `if_fault`=0.
  - `id_stall` with no flush: hold all fields.
- At most one request is outstanding. Responses arrive in order.

## Timing
- Reset values:
  - State = REQ.
  - `if_valid`=0, `if_pc`=0, `if_inst`=`NOP`, `if_fault`=0.
  - While `reset` is high: `imem_req_valid`=0, `imem_rsp_ready`=0, `pause`=1.
- Reset mid-fetch abandons the outstanding request. The memory is reset alongside, so no drain is required.
- Zero-wait memory (ready=1, response one cycle after acceptance):
  - Cycle N: req_fire.
  - Cycle N+1: rsp_fire.
  - Cycle N+2: `if_valid`=1 and the next request fires.
  - Throughput is one instruction per 2 cycles.
- `flush` is honoured in the same cycle:
  - No request is issued.
  - `if_valid`=0 from the next cycle.
  - The first request to the target is issued the next cycle (REQ), or after the stale response drains (DROP).
- Backpressure: under `id_stall` with `if_valid`=1, the response is not accepted (`imem_rsp_ready`=0). Memory holds `imem_rsp_valid` and data stable.

## Test plan
- Zero-wait memory, `pc` sequence 0x0, 0x4, 0x8 with words 0x00100093, 0x00200113, 0x00300193:
  - `if_inst` shows each word tagged with the matching `if_pc`.
  - `if_valid` pulses every 2nd cycle.
  - `pause` is low exactly in the req_fire cycles.
- `flush` in WAIT, cycle after the request to 0x8 is accepted, with PC redirected to 0x40:
  - State goes to DROP.
  - The 0x8 response is consumed and discarded.
  - The next request is to 0x40, and the next `if_pc` is 0x40.
- `flush` coincident with rsp_fire:
  - The word is discarded and `if_valid`=0 next cycle.
  - The request to the target issues the following cycle.
- `id_stall`=1 for 3 cycles while `if_valid`=1 and the response is pending:
  - `imem_rsp_ready`=0 and the IF/ID register is held.
  - The response is accepted the cycle the stall drops.
- `pc`=0x6:
  - No request is issued.
  - Outputs: `if_valid`=1, `if_fault`=1, `if_pc`=0x6, `if_inst`=0x00000013.
  - `pause` stays 1 until `flush`; a `flush` to 0x100 resumes fetch there.
- `imem_rsp_err`=1 on the fetch of 0x20:
  - Fault entry with `if_pc`=0x20, then HALT.
  - Assert `reset` mid-WAIT: all outputs return to their reset values next cycle.
